keypad_scan: RTL and testbench
==============================

# keypad_scan

Scans a 4x4 active-low matrix keypad and delivers one debounced 4-bit key code per press to the vending-machine controller through a valid/ack handshake. It drives the rows one-hot-low and reads the columns, the mirror image of the multiplexed seven-segment output path. Its codes use the same 4-bit digit space the display path consumes.

## Interface
- SCAN_DIV, 2000: clocks each row is driven before its columns are sampled; must be ≥ 4.
- DEBOUNCE_CNT, 20000: clocks of stable column pattern required to accept a press or a release.
- REPEAT_CNT, 500000: clocks between auto-repeat events (used only with KEYPAD_REPEAT_EN).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- col  in  4  keypad columns, active-low, externally pulled up; asynchronous.
- key_ack  in  1  consumer accepts key_code; sampled on the rising clock edge.
- row  out  4  row drive, one-hot-low (4'b1110 drives row 0).
- key_code  out  4  code of the accepted key.
- key_valid  out  1  key_code holds an unconsumed key.
- overrun  out  1  sticky: a key was accepted while key_valid was high and was dropped.

## Operation
- col passes through a 2-flop synchronizer; all logic uses the synchronized value colS.
- Key map, index 4·row+col: 1,2,3,A / 4,5,6,B / 7,8,9,C / E(*),0,F(#),D.
- State SCAN:
  - row rotates 1110→1101→1011→0111→1110, advancing after SCAN_DIV clocks.
  - colS is sampled on the last clock of each row period (div counter = SCAN_DIV-1).
  - If any bit of colS is low: capture row index r, the lowest low column c, and the colS pattern; go to DEBOUNCE; row freezes.
- State DEBOUNCE:
  - The counter increments each clock while colS equals the captured pattern.
  - Any mismatch: return to SCAN with the next row, and clear the counter.
  - Counter reaches DEBOUNCE_CNT: accept the key and go to HELD.
- Accept:
  - If key_valid=0, or key_ack is high in that same cycle: load key_code and set key_valid.
  - Otherwise drop the key and set overrun.
- State HELD:
  - row stays frozen.
  - colS must be 4'b1111 for DEBOUNCE_CNT consecutive clocks; any low bit restarts the count.
  - When the count completes: go to SCAN with the next row.
  - Multiple simultaneous keys: only the first captured key is reported; no second key is reported until all keys are released.
- Handshake:
  - key_code is stable while key_valid=1.
  - key_ack with key_valid=1 clears key_valid on the next edge.
  - key_ack with key_valid=0 is ignored.
  - key_ack also clears overrun.
  - If ack and accept fall in the same cycle, accept wins: new code loaded, key_valid stays 1, overrun cleared.

## Timing
- Reset (asynchronous, immediate): row=4'b1110, key_code=0, key_valid=0, overrun=0, state SCAN, all counters 0.
- Pin-to-colS latency: 2 clocks.
- key_valid rises DEBOUNCE_CNT+1 clocks after the detecting sample edge, provided the pattern is stable.
- key_valid falls 1 clock after the ack edge.
- Worst-case detection delay for a held key: 4·SCAN_DIV + 2 clocks.
- Counters saturate at their terminal value; no wrap-around.
- Reset asserted mid-debounce or mid-HELD: the press is discarded and scanning restarts at row 0; a still-held key is re-detected after release is not required (the next scan sees it as a new press).

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In HELD, a repeat counter runs while the captured pattern persists.
  - Every REPEAT_CNT clocks it re-accepts the same key, with the same accept/overrun rules as a fresh press.
  - The repeat counter clears on a release or a pattern change.
- KEYPAD_REPEAT_EN undefined: exactly one event per press; no repeat logic is synthesized.

## Test plan
- Parameters SCAN_DIV=4, DEBOUNCE_CNT=8; press row 2 / col 1 clean -> key_valid=1 with key_code=4'h8, DEBOUNCE_CNT+1 clocks after detection; ack -> key_valid=0 next clock.
- Press '*' bouncing 3 times at 2-clock intervals, then stable -> exactly one key_code=4'hE; no event during the bounce.
- Press '5', no ack, release, then press '#' -> key_code stays 4'h5 and overrun=1; ack clears both key_valid and overrun.
- Ack asserted in the same cycle a new key 'D' is accepted -> key_valid stays 1, key_code=4'hD, overrun=0.
- Assert rst_n low during DEBOUNCE -> row=4'b1110 and all outputs 0 immediately; release the key after reset -> no event.
- With KEYPAD_REPEAT_EN and REPEAT_CNT=32, hold '0' with prompt acks -> 4'h0 re-issued every 32 clocks; undefined -> a single event.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with debounce and a valid/ack key handshake.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan #(
    parameter int unsigned SCAN_DIV     = 2000,
    parameter int unsigned DEBOUNCE_CNT = 20000,
    parameter int unsigned REPEAT_CNT   = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    input  logic       key_ack,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       overrun
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CNT + 1);
`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_CNT);
`endif

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            4'd15:   code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] lowest_low(input logic [3:0] p);
        logic [1:0] idx;
        if (!p[0]) begin
            idx = 2'd0;
        end else if (!p[1]) begin
            idx = 2'd1;
        end else if (!p[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    logic [3:0]      col_meta_q, col_meta_d, col_sync_q, col_sync_d;
    state_t          state_q, state_d;
    logic [1:0]      row_idx_q, row_idx_d;
    logic [3:0]      row_q, row_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DB_W-1:0] db_q, db_d;
    logic [3:0]      pat_q, pat_d;
    logic [3:0]      code_q, code_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            overrun_q, overrun_d;
    logic            accept_s;
`ifdef KEYPAD_REPEAT_EN
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    // Scan / debounce / held sequencing and press capture
    always_comb begin
        col_meta_d = col;
        col_sync_d = col_meta_q;
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        div_d      = div_q;
        db_d       = db_q;
        pat_d      = pat_q;
        code_d     = code_q;
        accept_s   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d      = rep_q;
`endif
        case (state_q)
            ST_SCAN: begin
                if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                    div_d = '0;
                    if (col_sync_q != 4'hF) begin
                        state_d = ST_DEBOUNCE;
                        pat_d   = col_sync_q;
                        code_d  = key_map(row_idx_q, lowest_low(col_sync_q));
                        db_d    = '0;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (col_sync_q != pat_q) begin
                    state_d   = ST_SCAN;
                    row_idx_d = row_idx_q + 2'd1;
                    div_d     = '0;
                    db_d      = '0;
                end else if (db_q == DB_W'(DEBOUNCE_CNT)) begin
                    accept_s = 1'b1;
                    state_d  = ST_HELD;
                    db_d     = '0;
`ifdef KEYPAD_REPEAT_EN
                    rep_d    = '0;
`endif
                end else begin
                    db_d = db_q + DB_W'(1);
                end
            end
            ST_HELD: begin
                // Release must be seen as all-high for a full debounce window.
                if (col_sync_q != 4'hF) begin
                    db_d = '0;
                end else if (db_q == DB_W'(DEBOUNCE_CNT - 1)) begin
                    state_d   = ST_SCAN;
                    row_idx_d = row_idx_q + 2'd1;
                    div_d     = '0;
                    db_d      = '0;
                end else begin
                    db_d = db_q + DB_W'(1);
                end
`ifdef KEYPAD_REPEAT_EN
                if (col_sync_q == pat_q) begin
                    if (rep_q == REP_W'(REPEAT_CNT - 1)) begin
                        accept_s = 1'b1;
                        rep_d    = '0;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
                end else begin
                    rep_d = '0;
                end
`endif
            end
            default: begin
                state_d   = ST_SCAN;
                row_idx_d = 2'd0;
                div_d     = '0;
                db_d      = '0;
            end
        endcase
        row_d = ~(4'b0001 << row_idx_d);
    end

    // Consumer handshake: an accept beats a simultaneous ack
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        if (accept_s) begin
            if (!key_valid_q || key_ack) begin
                key_code_d  = code_q;
                key_valid_d = 1'b1;
                if (key_ack) begin
                    overrun_d = 1'b0;
                end else begin
                    overrun_d = overrun_q;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end else if (key_ack) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            key_valid_d = key_valid_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q  <= 4'hF;
            col_sync_q  <= 4'hF;
            state_q     <= ST_SCAN;
            row_idx_q   <= 2'd0;
            row_q       <= 4'b1110;
            div_q       <= '0;
            db_q        <= '0;
            pat_q       <= 4'hF;
            code_q      <= 4'h0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            col_meta_q  <= col_meta_d;
            col_sync_q  <= col_sync_d;
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            row_q       <= row_d;
            div_q       <= div_d;
            db_q        <= db_d;
            pat_q       <= pat_d;
            code_q      <= code_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat interval counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    assign row       = row_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized self-checking bench for keypad_scan with a keypad model and handshake scoreboard.
module tb_keypad_scan;

    localparam int S = 4;
    localparam int D = 8;
    localparam int R = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] col;
    logic       key_ack = 1'b0;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       overrun;

    logic [15:0] keys = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;

    logic [3:0] key_map_tb [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                    4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    logic       exp_valid = 1'b0;
    logic [3:0] exp_code = 4'h0;
    logic       exp_ovr = 1'b0;

    keypad_scan #(.SCAN_DIV(S), .DEBOUNCE_CNT(D), .REPEAT_CNT(R)) dut (
        .clk(clk), .rst_n(rst_n), .col(col), .key_ack(key_ack),
        .row(row), .key_code(key_code), .key_valid(key_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Passive keypad: a pressed key shorts its column to its row line
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_valid"}, key_valid, exp_valid);
        check_eq({tag, "_code"}, key_code, exp_code);
        check_eq({tag, "_ovr"}, overrun, exp_ovr);
    endtask

    task automatic model_accept(input logic [3:0] code, input logic ack);
        if (!exp_valid || ack) begin
            exp_code  = code;
            exp_valid = 1'b1;
            if (ack) exp_ovr = 1'b0;
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    task automatic model_ack();
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
        model_ack();
    endtask

    task automatic release_keys();
        keys = '0;
        tick(2 * D + 4);
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            tick(1);
            if (key_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_ovr(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            tick(1);
            if (overrun) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Press a key just as the scanner starts driving its row
    task automatic press_aligned(input int idx);
        logic [3:0] target;
        logic [3:0] prev;
        bit         ok;
        target = ~(4'b0001 << idx[3:2]);
        ok = 1'b0;
        for (int i = 0; i < 10 * S; i++) begin
            prev = row;
            tick(1);
            if (row == target && prev != target) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("row_align", {31'd0, ok}, 32'd1);
        keys[idx] = 1'b1;
    endtask

    initial begin
        int  cyc;
        int  idx;
        int  t_prev;
        bit  seen;

        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_row", row, 4'b1110);
        check_outputs("rst");
        tick(3);
        rst_n = 1'b1;

        // Clean presses with exact latency: row 2 / col 1 first, then random keys
        for (int k = 0; k < 7; k++) begin
            idx = (k == 0) ? 9 : int'($urandom_range(0, 15));
            press_aligned(idx);
            wait_valid(S + D + 10, cyc);
            check_eq("press_latency", cyc, S + D + 1);
            model_accept(key_map_tb[idx], 1'b0);
            check_outputs("press");
            do_ack();
            check_outputs("ack");
            release_keys();
        end

        // Bouncing '*' yields exactly one event
        seen = 1'b0;
        for (int b = 0; b < 3; b++) begin
            keys[12] = 1'b1;
            for (int i = 0; i < 2; i++) begin tick(1); if (key_valid) seen = 1'b1; end
            keys[12] = 1'b0;
            for (int i = 0; i < 2; i++) begin tick(1); if (key_valid) seen = 1'b1; end
        end
        check_eq("bounce_quiet", {31'd0, seen}, 32'd0);
        keys[12] = 1'b1;
        wait_valid(4 * S + D + 12, cyc);
        check_eq("bounce_detect", {31'd0, (cyc > 0)}, 32'd1);
        model_accept(key_map_tb[12], 1'b0);
        check_outputs("bounce");
        do_ack();
        keys = '0;
        seen = 1'b0;
        for (int i = 0; i < 3 * D; i++) begin tick(1); if (key_valid) seen = 1'b1; end
        check_eq("bounce_single", {31'd0, seen}, 32'd0);

        // '5' unacked, then '#' is dropped with overrun
        press_aligned(5);
        wait_valid(S + D + 10, cyc);
        model_accept(key_map_tb[5], 1'b0);
        check_outputs("ovr_first");
        release_keys();
        press_aligned(14);
        wait_ovr(S + D + 10, cyc);
        model_accept(key_map_tb[14], 1'b0);
        check_outputs("ovr_set");
        release_keys();
        check_outputs("ovr_hold");
        do_ack();
        check_outputs("ovr_ack");

        // Ack coinciding with the accept of 'D'
        idx = int'($urandom_range(0, 15));
        press_aligned(idx);
        wait_valid(S + D + 10, cyc);
        model_accept(key_map_tb[idx], 1'b0);
        release_keys();
        idx = int'($urandom_range(0, 15));
        press_aligned(idx);
        wait_ovr(S + D + 10, cyc);
        model_accept(key_map_tb[idx], 1'b0);
        release_keys();
        check_outputs("coinc_pre");
        press_aligned(15);
        tick(S + D);
        check_outputs("coinc_before");
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
        model_accept(key_map_tb[15], 1'b1);
        check_outputs("coinc");
        release_keys();

        // Reset while debouncing discards the press
        idx = int'($urandom_range(0, 15));
        press_aligned(idx);
        tick(S + 3);
        #2 rst_n = 1'b0;
        #1;
        exp_valid = 1'b0; exp_code = 4'h0; exp_ovr = 1'b0;
        check_eq("mid_rst_row", row, 4'b1110);
        check_outputs("mid_rst");
        keys = '0;
        tick(2);
        rst_n = 1'b1;
        tick(4 * S + D + 10);
        check_outputs("post_rst");

        // Held '0' with prompt acks: repeats only when auto-repeat is built in
        keys[13] = 1'b1;
        wait_valid(4 * S + D + 12, cyc);
        model_accept(key_map_tb[13], 1'b0);
        check_outputs("hold_first");
        t_prev = cycle;
        do_ack();
`ifdef KEYPAD_REPEAT_EN
        for (int k = 0; k < 4; k++) begin
            wait_valid(R + 8, cyc);
            check_eq("repeat_interval", cycle - t_prev, R);
            t_prev = cycle;
            model_accept(key_map_tb[13], 1'b0);
            check_outputs("repeat");
            do_ack();
        end
`else
        wait_valid(3 * R, cyc);
        check_eq("no_repeat", cyc, -1);
`endif
        release_keys();
        check_outputs("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
